fb_access_ctrl: RTL and testbench
=================================

Name: fb_access_ctrl

Overview:
Controller that shares one single-port frame-buffer RAM between three users: the VGA scan-out reader, a pixel-write requester and a built-in clear engine. It sits between the 25 MHz timing generator (pos_x/pos_y/active) and the RAM, and drives the 1-bit RGB outputs. The display always wins the port. Writes and clears use the port only in cycles the display does not.

Parameters:
FB_W, 8, frame-buffer width in pixels
FB_H, 8, frame-buffer height in pixels
AW, 6, RAM address width; must satisfy 2**AW >= FB_W*FB_H
CW, 3, colour width; bit 2 = red, bit 1 = green, bit 0 = blue

Ports:
clk25MHz  in  1  pixel clock, sole clock
rst  in  1  synchronous reset, active-high
pos_x  in  9  current scan column
pos_y  in  9  current scan row
active  in  1  visible-area flag from timing generator
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle when high together with wr_valid
wr_x  in  9  write column
wr_y  in  9  write row
wr_color  in  CW  write colour
clr_start  in  1  single-cycle pulse that starts a full clear
clr_busy  out  1  clear in progress
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address = y*FB_W + x
mem_wdata  out  CW  RAM write data
mem_rdata  in  CW  RAM read data, valid one cycle after a read
o_red  out  1  pixel red
o_green  out  1  pixel green
o_blue  out  1  pixel blue

Behaviour:
- Clock and reset: one clock (clk25MHz). Reset is synchronous and active-high (rst).
- Reset: state = IDLE. clr_busy = 0, wr_ready = 0, pipeline flags = 0, colour register = 0, o_* = 0.
- RAM port is combinational from the current arbitration decision.
  - Idle value: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Display hit: disp_rd = active && pos_x < FB_W && pos_y < FB_H.
  - When disp_rd is high: mem_en = 1, mem_we = 0, mem_addr = pos_y*FB_W + pos_x.
- Read pipeline:
  - Stage 1 registers hit1 = disp_rd and act1 = active.
  - Stage 2 captures colour = hit1 ? mem_rdata : 0 and registers act2 = act1.
  - o_red/o_green/o_blue = act2 ? colour bits : 0.
  - Total latency from pos sample to colour output is 2 cycles.
- Priority, highest first: display read, clear write, external write.
- FSM states:
  - IDLE -> CLEAR on clr_start (clr_busy goes high the next cycle).
  - CLEAR -> IDLE after the write to address FB_W*FB_H-1.
  - clr_start is ignored while in CLEAR.
- Clear engine:
  - In CLEAR, each cycle with !disp_rd: mem_en = 1, mem_we = 1, mem_addr = clr_cnt, mem_wdata = 0, then clr_cnt increments.
  - Cycles with disp_rd are stolen from the clear; clr_cnt holds.
  - clr_cnt resets to 0 on entry to CLEAR.
- Write handshake:
  - wr_ready = !rst && state == IDLE && !disp_rd. It is combinational and does not depend on wr_valid.
  - Transfer occurs on wr_valid && wr_ready.
  - In-range transfer: mem_en = 1, mem_we = 1, mem_addr = wr_y*FB_W + wr_x, mem_wdata = wr_color, in the same cycle.
  - Out-of-range transfer (wr_x >= FB_W or wr_y >= FB_H): handshake completes and mem_en stays 0 (write dropped).
- A requester must hold wr_* stable while wr_valid && !wr_ready.
- Address arithmetic is unsigned, computed at AW bits wide, and only used when coordinates are in range.
- Reset mid-clear aborts the clear: clr_busy = 0 the next cycle and RAM contents are left partially cleared.
- clr_start arriving in the same cycle as a write transfer: the write completes, and CLEAR begins the next cycle.

Optional Feature:
FB_CLEAR_EN.
- Defined: CLEAR state, clr_cnt and clear writes exist as described above.
- Undefined:
  - FSM is permanently IDLE.
  - clr_start is ignored.
  - clr_busy is tied to 0.
  - No counter logic is built.
  - Ports are unchanged.

Decomposition:
- Shared package fb_pkg holds:
  - default FB_W/FB_H/CW
  - colour bit-index constants (RED = 2, GREEN = 1, BLUE = 0)
  - state typedef {IDLE, CLEAR}
  - an xy-to-address function
- One sub-module, fb_clear_engine:
  - Inputs: start, stall (= disp_rd).
  - Outputs: busy, wr_en, addr.
  - Contains the FSM and clr_cnt.
  - Instantiated only under FB_CLEAR_EN.

Test Plan:
1. Reset: hold rst 3 cycles with wr_valid = 1, active = 1 -> wr_ready = 0, o_* = 0, clr_busy = 0. mem_en = 0 on the cycles the display is out of region.
2. Preload RAM[26] = 3'b101, drive active = 1, pos = (2,3) -> same cycle mem_en = 1, mem_we = 0, mem_addr = 26; two cycles later o_red = 1, o_green = 0, o_blue = 1.
3. Contention: active = 1, pos = (1,1), wr_valid = 1 with (5,5,3'b010) -> wr_ready = 0. Drop active -> wr_ready = 1 that cycle with mem_we = 1, mem_addr = 45, mem_wdata = 3'b010.
4. Out-of-range write (8,0) with active = 0 -> wr_ready = 1, transfer in 1 cycle, mem_en = 0; RAM unchanged.
5. Clear (FB_CLEAR_EN defined), active = 0: pulse clr_start -> clr_busy = 1 for 64 cycles, addresses 0..63 written with 0, wr_ready = 0 throughout. Repeat with active high for 10 in-region cycles -> busy lasts 74 cycles.
6. Assert rst at clr_cnt = 20 -> clr_busy = 0 the next cycle and RAM[21..63] unchanged. Separately, active = 1, pos = (9,0) -> o_* = 0 and wr_ready = 1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer access controller.
// Build option FB_CLEAR_EN (see fb_access_ctrl) enables the clear engine.
package fb_pkg;

  localparam int FB_W_DEF = 8;
  localparam int FB_H_DEF = 8;
  localparam int AW_DEF   = 6;
  localparam int CW_DEF   = 3;

  localparam int RED   = 2;
  localparam int GREEN = 1;
  localparam int BLUE  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Linear address y*fb_w + x; callers truncate to their RAM address width.
  function automatic int unsigned xy_to_addr(input logic [8:0] x,
                                             input logic [8:0] y,
                                             input int unsigned fb_w);
    return (32'(y) * fb_w) + 32'(x);
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Clear engine: walks every frame-buffer address once, writing zero,
// pausing on cycles the display owns the RAM port.
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_W_DEF * FB_H_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk25MHz,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          wr_en,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fb_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns the next-state values; a missing path would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (!stall) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25MHz) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == CLEAR);
  // A reset cycle aborts the clear without issuing one more write.
  assign wr_en = busy && !stall && !rst;
  assign addr  = cnt_q;

endmodule

// File: rtl/fb_access_ctrl.sv
// Single-port frame-buffer arbiter: display read > clear write > pixel write.
// Define FB_CLEAR_EN to build the clear engine; otherwise clr_start is ignored.
module fb_access_ctrl
  import fb_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF,
  parameter int AW   = AW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic          clk25MHz,
  input  logic          rst,
  input  logic [8:0]    pos_x,
  input  logic [8:0]    pos_y,
  input  logic          active,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [8:0]    wr_x,
  input  logic [8:0]    wr_y,
  input  logic [CW-1:0] wr_color,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [CW-1:0] mem_wdata,
  input  logic [CW-1:0] mem_rdata,
  output logic          o_red,
  output logic          o_green,
  output logic          o_blue
);

  localparam logic [8:0] W9 = 9'(FB_W);
  localparam logic [8:0] H9 = 9'(FB_H);

  logic          disp_rd, wr_in_range, wr_fire;
  logic          clr_wr;
  logic [AW-1:0] clr_addr, disp_addr, wr_addr;

  assign disp_rd     = active && (pos_x < W9) && (pos_y < H9);
  assign wr_in_range = (wr_x < W9) && (wr_y < H9);
  assign disp_addr   = AW'(xy_to_addr(pos_x, pos_y, FB_W));
  assign wr_addr     = AW'(xy_to_addr(wr_x, wr_y, FB_W));

  assign wr_ready = !rst && !clr_busy && !disp_rd;
  // Out-of-range transfers complete the handshake but never reach the RAM.
  assign wr_fire  = wr_valid && wr_ready && wr_in_range;

`ifdef FB_CLEAR_EN
  fb_clear_engine #(
    .DEPTH (FB_W * FB_H),
    .AW    (AW)
  ) u_clear (
    .clk25MHz (clk25MHz),
    .rst      (rst),
    .start    (clr_start),
    .stall    (disp_rd),
    .busy     (clr_busy),
    .wr_en    (clr_wr),
    .addr     (clr_addr)
  );
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clr_busy = 1'b0;
  assign clr_wr   = 1'b0;
  assign clr_addr = '0;
`endif

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_rd) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (clr_wr) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = clr_addr;
    end else if (wr_fire) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_color;
    end
  end

  // Two-stage read pipeline aligning RAM data with the delayed active flag.
  logic          hit1_q, hit1_d, act1_q, act1_d, act2_q, act2_d;
  logic [CW-1:0] colour_q, colour_d;

  always_comb begin
    hit1_d   = disp_rd;
    act1_d   = active;
    colour_d = hit1_q ? mem_rdata : '0;
    act2_d   = act1_q;
  end

  always_ff @(posedge clk25MHz) begin
    // NOTE: only the pipeline is reset; the external RAM keeps its contents, so a reset mid-clear leaves it partly cleared.
    if (rst) begin
      hit1_q   <= 1'b0;
      act1_q   <= 1'b0;
      colour_q <= '0;
      act2_q   <= 1'b0;
    end else begin
      hit1_q   <= hit1_d;
      act1_q   <= act1_d;
      colour_q <= colour_d;
      act2_q   <= act2_d;
    end
  end

  assign o_red   = act2_q & colour_q[RED];
  assign o_green = act2_q & colour_q[GREEN];
  assign o_blue  = act2_q & colour_q[BLUE];

endmodule

// File: tb/tb_fb_access_ctrl.sv
// Bench for fb_access_ctrl: behavioural RAM, vector table for the port
// arbitration, and a pixel scoreboard fed from a shadow copy of the RAM.
module tb_fb_access_ctrl;

  logic       clk25MHz = 1'b0;
  logic       rst, active, wr_valid, wr_ready, clr_start, clr_busy;
  logic [8:0] pos_x, pos_y, wr_x, wr_y;
  logic [2:0] wr_color, mem_wdata, mem_rdata;
  logic       mem_en, mem_we, o_red, o_green, o_blue;
  logic [5:0] mem_addr;

  int total = 0;
  int bad   = 0;
  int pix_idx = 0;

  logic [2:0] ram    [64];
  logic [2:0] shadow [64];
  logic [2:0] rdata_r;
  logic [2:0] pq [$];

  always #20 clk25MHz = ~clk25MHz;

  fb_access_ctrl dut (
    .clk25MHz  (clk25MHz),
    .rst       (rst),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .active    (active),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .o_red     (o_red),
    .o_green   (o_green),
    .o_blue    (o_blue)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk25MHz) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rdata_r       <= ram[mem_addr];
    end
  end
  assign mem_rdata = rdata_r;

  typedef struct {
    bit r; bit a; int px; int py;
    bit wv; int wx; int wy; int wc; bit cs;
    bit e_rdy; bit e_en; bit e_we; int e_addr; int e_wd;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, exp);
    end
  endtask

  // Expected pixel for the current inputs, compared two cycles later.
  task automatic pixel_sb();
    logic [2:0] e;
    e = 3'b000;
    if (!rst && active && pos_x < 9'd8 && pos_y < 9'd8)
      e = shadow[int'(pos_y) * 8 + int'(pos_x)];
    pq.push_back(e);
    if (pq.size() > 2) begin
      e = pq.pop_front();
      check("pixel", pix_idx, {29'd0, o_red, o_green, o_blue}, {29'd0, e});
      pix_idx++;
    end
  endtask

  task automatic drive(input bit r, input bit a, input int px, input int py,
                       input bit wv, input int wx, input int wy, input int wc, input bit cs);
    @(negedge clk25MHz);
    rst = r; active = a; pos_x = 9'(px); pos_y = 9'(py);
    wr_valid = wv; wr_x = 9'(wx); wr_y = 9'(wy); wr_color = 3'(wc); clr_start = cs;
    #5;
    pixel_sb();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.r, v.a, v.px, v.py, v.wv, v.wx, v.wy, v.wc, v.cs);
    check("wr_ready",  idx, wr_ready,  v.e_rdy);
    check("mem_en",    idx, mem_en,    v.e_en);
    check("mem_we",    idx, mem_we,    v.e_we);
    check("mem_addr",  idx, mem_addr,  v.e_addr);
    check("mem_wdata", idx, mem_wdata, v.e_wd);
    check("clr_busy",  idx, clr_busy,  1'b0);
    if (v.e_en && v.e_we) shadow[v.e_addr] = 3'(v.e_wd);
  endtask

  // Write every location through the request port.
  task automatic fill(input bit sel);
    vec_t v;
    int c;
    for (int i = 0; i < 64; i++) begin
      c = sel ? ((i * 5 + 3) & 7) : ((~i) & 7);
      v = '{1'b0, 1'b0, 0, 0, 1'b1, i % 8, i / 8, c, 1'b0, 1'b1, 1'b1, 1'b1, i, c};
      apply_vec(v, 100 + i);
    end
  endtask

  task automatic ram_cmp(input string nm, input int skip);
    int nz;
    nz = 0;
    for (int i = 0; i < 64; i++)
      if (i != skip && ram[i] !== shadow[i]) nz++;
    check(nm, 0, nz, 0);
  endtask

  // Full raster including out-of-region columns/rows.
  task automatic scan();
    vec_t v;
    bit in;
    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 10; x++) begin
        in = (x < 8) && (y < 8);
        v = '{1'b0, 1'b1, x, y, 1'b0, 0, 0, 0, 1'b0, !in, in, 1'b0, in ? y * 8 + x : 0, 0};
        apply_vec(v, 200 + y * 10 + x);
      end
  endtask

`ifdef FB_CLEAR_EN
  // Runs until clr_busy drops (bounded); display steals cycles steal_lo..steal_hi.
  task automatic run_clear(input int steal_lo, input int steal_hi, output int n_busy);
    int cnt;
    bit st;
    cnt = 0;
    n_busy = 0;
    for (int c = 0; c < 200; c++) begin
      st = (c >= steal_lo) && (c <= steal_hi);
      drive(1'b0, st, c % 8, 2, 1'b0, 0, 0, 0, 1'b0);
      if (!clr_busy) begin
        check("clr_exit_en", c, mem_en, 1'b0);
        break;
      end
      n_busy++;
      check("clr_rdy", c, wr_ready, 1'b0);
      check("clr_en",  c, mem_en,   1'b1);
      if (st) begin
        check("steal_we",   c, mem_we,   1'b0);
        check("steal_addr", c, mem_addr, 16 + c % 8);
      end else begin
        check("clr_we",    c, mem_we,    1'b1);
        check("clr_addr",  c, mem_addr,  cnt);
        check("clr_wdata", c, mem_wdata, 0);
        shadow[cnt % 64] = 3'b000;
        cnt++;
      end
    end
  endtask
`endif

  initial begin
    int n;
    vec_t pulse, quiet;
    for (int i = 0; i < 64; i++) shadow[i] = 3'b000;

    tbl[0]  = '{1'b1, 1'b1, 9, 0, 1'b1, 1, 1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 2, 3, 1'b1, 1, 1, 7, 1'b0, 1'b0, 1'b1, 1'b0, 26, 0};
    tbl[2]  = '{1'b1, 1'b1, 9, 0, 1'b1, 1, 1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 2, 3, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 26, 0};
    tbl[4]  = '{1'b0, 1'b1, 1, 1, 1'b1, 5, 5, 2, 1'b0, 1'b0, 1'b1, 1'b0, 9, 0};
    tbl[5]  = '{1'b0, 1'b0, 1, 1, 1'b1, 5, 5, 2, 1'b0, 1'b1, 1'b1, 1'b1, 45, 2};
    tbl[6]  = '{1'b0, 1'b0, 0, 0, 1'b1, 8, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 0, 0, 1'b1, 0, 8, 6, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 9, 0, 1'b1, 3, 4, 6, 1'b0, 1'b1, 1'b1, 1'b1, 35, 6};
    tbl[9]  = '{1'b0, 1'b1, 0, 8, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 4, 4, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 7, 7, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 63, 0};
    tbl[12] = '{1'b0, 1'b1, 8, 7, 1'b1, 7, 7, 4, 1'b0, 1'b1, 1'b1, 1'b1, 63, 4};
    quiet   = '{1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};

    // One unchecked reset cycle so the flops have a defined value.
    drive(1'b1, 1'b1, 9, 0, 1'b1, 1, 1, 7, 1'b0);
    for (int i = 0; i < 3; i++) apply_vec(tbl[i], i);
    check("o_after_rst", 0, {o_red, o_green, o_blue}, 3'b000);

    fill(1'b0);
    for (int i = 3; i < 13; i++) apply_vec(tbl[i], i);
    idle();
    ram_cmp("ram_after_tbl", -1);
    scan();
    idle();
    ram_cmp("ram_after_scan", -1);

`ifdef FB_CLEAR_EN
    // clr_start together with a write transfer: the write lands, then the clear runs.
    pulse = '{1'b0, 1'b0, 0, 0, 1'b1, 4, 4, 1, 1'b1, 1'b1, 1'b1, 1'b1, 36, 1};
    apply_vec(pulse, 300);
    run_clear(-1, -2, n);
    check("clr_len", 0, n, 64);
    ram_cmp("ram_cleared", -1);

    pulse = '{1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    apply_vec(pulse, 301);
    run_clear(5, 14, n);
    check("clr_len_steal", 0, n, 74);

    // Reset while clr_cnt = 20 aborts the clear.
    fill(1'b1);
    apply_vec(pulse, 302);
    for (int k = 0; k < 20; k++) begin
      idle();
      check("mc_busy", k, clr_busy, 1'b1);
      check("mc_addr", k, mem_addr, k);
      check("mc_we",   k, mem_we,   1'b1);
      shadow[k] = 3'b000;
    end
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    idle();
    check("mc_busy_after_rst", 0, clr_busy, 1'b0);
    check("mc_rdy_after_rst",  0, wr_ready, 1'b1);
    check("mc_en_after_rst",   0, mem_en,   1'b0);
    ram_cmp("ram_partial", 20);
`else
    pulse = '{1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    apply_vec(pulse, 300);
    for (int i = 0; i < 3; i++) apply_vec(quiet, 301 + i);
`endif

    for (int i = 0; i < 3; i++) apply_vec(quiet, 400 + i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
